// File: rtl/mem_responder_pkg.sv
// Shared memory-access encodings for the RV32I memory responder.
// Holds the load/store width encodings and the responder FSM state constants.
package mem_responder_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_t;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t IDLE    = 2'd0;
    localparam mem_state_t ACCESS  = 2'd1;
    localparam mem_state_t RESPOND = 2'd2;

endpackage

// File: rtl/mem_responder_lane_align.sv
// Combinational RV32I lane logic: byte enables and replicated store data,
// extended load data and the misaligned/illegal-funct3 flag.
import mem_responder_pkg::*;

module mem_responder_lane_align (
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rword_i >> {offset_i, 3'b000});
        half_sel = 16'(rword_i >> {offset_i[1], 4'b0000});
        be_o     = 4'b0000;
        wdata_o  = 32'h0;
        rdata_o  = 32'h0;
        err_o    = 1'b0;

        // Store data is replicated across lanes; the byte enables pick the live ones.
        case (funct3_i)
            MEM_B: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            MEM_BU: begin
                err_o   = we_i;
                rdata_o = {24'h0, byte_sel};
            end
            MEM_H: begin
                err_o   = offset_i[0];
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            MEM_HU: begin
                err_o   = we_i | offset_i[0];
                rdata_o = {16'h0, half_sel};
            end
            MEM_W: begin
                err_o   = (offset_i != 2'b00);
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: err_o = 1'b1;
        endcase

        if (err_o) begin
            be_o    = 4'b0000;
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding valid/ready memory responder for the multicycle RV32I core:
// word-organised RAM with byte/half/word lanes, error detection and wait states.
import mem_responder_pkg::*;

module mem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_rdata_o,
    output logic             rsp_err_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rdata_ext;
    logic             align_err;
    logic             range_err;
    logic             err_all;
    logic             last_access;
    logic             do_write;

    assign idx       = addr_q[IDX_W+1:2];
    assign rword     = mem[idx];
    assign range_err = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign err_all   = align_err | range_err;

    assign last_access = (state_q == ACCESS) && (cnt_q == 4'(WAIT_STATES));
    // Reset on the commit edge must still drop the store.
    assign do_write    = last_access && we_q && !err_all && !rst_i;

    mem_responder_lane_align u_lane_align (
        .funct3_i (funct3_q),
        .we_i     (we_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rword_i  (rword),
        .be_o     (be),
        .wdata_o  (wdata_sh),
        .rdata_o  (rdata_ext),
        .err_o    (align_err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d  = ACCESS;
                    cnt_d    = 4'd0;
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                end
            end
            ACCESS: begin
                if (last_access) begin
                    state_d = RESPOND;
                    err_d   = err_all;
                    rdata_d = (we_q || err_all) ? 32'h0 : rdata_ext;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESPOND: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESPOND);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance 0 has no wait states, instance 1 has three.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    // Issue one request on instance d and return its response (bounded waits).
    task automatic xact(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e);
        int n;
        @(negedge clk);
        req_we[d] = we; req_funct3[d] = f3; req_addr[d] = a; req_wdata[d] = wd;
        req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_valid[d] && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid[d] !== 1'b1)
            $display("FAIL response_timeout dut%0d addr %h: got rsp_valid %b want 1", d, a, rsp_valid[d]);
        else passes++;
        rd = rsp_rdata[d]; e = rsp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1; rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]} !== {1'b1, 1'b0, 32'h0, 1'b0})
                $display("FAIL reset_state dut%0d: got ready %b valid %b rdata %h err %b want 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            else passes++;
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic e;
        xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e);
        checks++;
        if ({rd, e} !== {32'h0, 1'b0}) $display("FAIL sw_rsp: got %h/%b want 0/0", rd, e);
        else passes++;
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        checks++;
        if ({rd, e} !== {32'hDEADBEEF, 1'b0}) $display("FAIL lw_0x10: got %h/%b want deadbeef/0", rd, e);
        else passes++;
    endtask

    task automatic test_load_lanes();
        logic [2:0]  f3s [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h10, 32'h13, 32'h12, 32'h10};
        logic [31:0] exps [4] = '{32'hFFFFFFEF, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        logic [31:0] rd; logic e;
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b0, f3s[i], adrs[i], 32'h0, rd, e);
            checks++;
            if ({rd, e} !== {exps[i], 1'b0})
                $display("FAIL load_lane%0d f3 %b @%h: got %h/%b want %h/0", i, f3s[i], adrs[i], rd, e, exps[i]);
            else passes++;
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] rd; logic e;
        xact(0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA55, rd, e);
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        checks++;
        if (rd !== 32'hDEAD55EF) $display("FAIL sb_0x11: got %h want dead55ef", rd);
        else passes++;
        xact(0, 1'b1, 3'b001, 32'h12, 32'hBBBB1234, rd, e);
        checks++;
        if ({rd, e} !== {32'h0, 1'b0}) $display("FAIL sh_rsp: got %h/%b want 0/0", rd, e);
        else passes++;
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h123455EF) $display("FAIL sh_0x12: got %h want 123455ef", rd);
        else passes++;
    endtask

    task automatic test_errors();
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        logic [31:0] adrs [5] = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h1000};
        logic [31:0] rd; logic e;
        for (int i = 0; i < 5; i++) begin
            xact(0, wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, rd, e);
            checks++;
            if ({rd, e} !== {32'h0, 1'b1})
                $display("FAIL error_case%0d we %b f3 %b @%h: got %h/%b want 0/1", i, wes[i], f3s[i], adrs[i], rd, e);
            else passes++;
        end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        checks++;
        if ({rd, e} !== {32'h123455EF, 1'b0}) $display("FAIL after_errors: got %h/%b want 123455ef/0", rd, e);
        else passes++;
    endtask

    task automatic test_wait_backpressure();
        logic [31:0] rd; logic e; int n;
        xact(1, 1'b1, 3'b010, 32'h40, 32'h11223344, rd, e);
        @(negedge clk);
        req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h40;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        checks++;
        if (req_ready[1] !== 1'b1) $display("FAIL ws_idle_ready: got %b want 1", req_ready[1]);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({rsp_valid[1], req_ready[1]} !== {(i == 4), 1'b0})
                $display("FAIL ws_latency after edge k+%0d: got valid %b ready %b want %b 0",
                         i, rsp_valid[1], req_ready[1], (i == 4));
            else passes++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1]} !== {1'b1, 32'h11223344, 1'b0, 1'b0})
                $display("FAIL ws_hold cycle %0d: got valid %b rdata %h err %b ready %b want 1 11223344 0 0",
                         i, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1]);
            else passes++;
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid[1], req_ready[1]} !== 2'b01)
            $display("FAIL ws_exit_cycle: got valid %b ready %b want 0 1", rsp_valid[1], req_ready[1]);
        else passes++;
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b0) $display("FAIL ws_reaccept: got ready %b want 0", req_ready[1]);
        else passes++;
        req_valid[1] = 1'b0;
        n = 0;
        while (!rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({rsp_valid[1], rsp_rdata[1]} !== {1'b1, 32'h11223344})
            $display("FAIL ws_second_rsp: got valid %b rdata %h want 1 11223344", rsp_valid[1], rsp_rdata[1]);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic e; logic seen; int n;
        xact(1, 1'b1, 3'b010, 32'h20, 32'h0, rd, e);
        // Reset during ACCESS drops the store.
        @(negedge clk);
        req_we[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = 32'h20; req_wdata[1] = 32'hA5A5A5A5;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk); rst[1] = 1'b1;
        @(negedge clk); rst[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= rsp_valid[1];
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL rst_access_no_rsp: got rsp_valid seen %b want 0", seen);
        else passes++;
        xact(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h0) $display("FAIL rst_access_lw: got %h want 00000000", rd);
        else passes++;
        // Reset during RESPOND keeps the committed write.
        @(negedge clk);
        req_we[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = 32'h20; req_wdata[1] = 32'hA5A5A5A5;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
        rst[1] = 1'b1;
        @(negedge clk); rst[1] = 1'b0;
        checks++;
        if ({rsp_valid[1], req_ready[1], rsp_rdata[1]} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL rst_respond_state: got valid %b ready %b rdata %h want 0 1 0",
                     rsp_valid[1], req_ready[1], rsp_rdata[1]);
        else passes++;
        xact(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e);
        checks++;
        if (rd !== 32'hA5A5A5A5) $display("FAIL rst_respond_lw: got %h want a5a5a5a5", rd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_load_lanes();
        test_store_lanes();
        test_errors();
        test_wait_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
